// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller for one player character.
// Latches the character state once per video frame, steps the idle/walk
// animation frame index, and turns sprite-local pixel coordinates into a
// unified sprite ROM address (three banks of frames, optional mirroring).
// The pixel comes back to the mixer with a transparency flag three cycles
// after the coordinates were presented.
module sprite_anim_ctrl #(
    parameter int                SPR_W    = 47,
    parameter int                SPR_H    = 60,
    parameter int                N_FRAMES = 4,
    parameter int                TICK_DIV = 4,
    parameter int                PIX_W    = 12,
    parameter logic [PIX_W-1:0]  KEY_COL  = '0,
    parameter int                ADDR_W   = 16,
    localparam int               FRAME_W  = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [2:0]         state_i,
    input  logic               in_valid,
    input  logic [7:0]         pix_x,
    input  logic [7:0]         pix_y,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [PIX_W-1:0]   rom_data,
    output logic [PIX_W-1:0]   pix_out,
    output logic               pix_valid,
    output logic               pix_opaque,
    output logic [FRAME_W-1:0] anim_frame
);

    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;

    // Animation class doubles as the ROM bank number.
    typedef enum logic [1:0] {
        CLS_IDLE = 2'd0,
        CLS_WALK = 2'd1,
        CLS_JUMP = 2'd2
    } anim_cls_t;

    function automatic anim_cls_t class_of(input logic [2:0] st);
        if (st[1])
            return CLS_JUMP;
        else if (st[2])
            return CLS_WALK;
        return CLS_IDLE;
    endfunction

    logic [2:0]         state_reg, state_next;
    logic [FRAME_W-1:0] frame_reg, frame_next;
    logic [TICK_W-1:0]  tick_reg,  tick_next;

    anim_cls_t          cls_cur;
    logic               in_range;
    logic [ADDR_W-1:0]  col_val;
    logic [ADDR_W-1:0]  addr_calc;
    logic [ADDR_W-1:0]  bank_base [4];

    logic               vld1_reg, vld2_reg;
    logic               oob1_reg, oob2_reg;

    // Base address of each bank, all constants (slot 3 is never selected).
    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        assign bank_base[gi] = ADDR_W'(gi * N_FRAMES * FRAME_SZ);
    end

    // Animation state register: only ever changes on frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= 3'b001;
            frame_reg <= '0;
            tick_reg  <= '0;
        end else begin
            state_reg <= state_next;
            frame_reg <= frame_next;
            tick_reg  <= tick_next;
        end
    end

    // Next animation state: restart on class/direction change, hold in jump,
    // otherwise divide frame pulses down and step the frame index with wrap.
    always_comb begin
        state_next = state_reg;
        frame_next = frame_reg;
        tick_next  = tick_reg;
        if (frame_start) begin
            state_next = state_i;
            if ((class_of(state_i) != class_of(state_reg)) ||
                (state_i[0] != state_reg[0])) begin
                frame_next = '0;
                tick_next  = '0;
            end else if (class_of(state_reg) == CLS_JUMP) begin
                frame_next = '0;
                tick_next  = '0;
            end else if (tick_reg == TICK_W'(TICK_DIV - 1)) begin
                tick_next  = '0;
                frame_next = (frame_reg == FRAME_W'(N_FRAMES - 1)) ?
                             '0 : frame_reg + FRAME_W'(1);
            end else begin
                tick_next = tick_reg + TICK_W'(1);
            end
        end
    end

    assign anim_frame = frame_reg;

    // Address arithmetic from the latched state: constant multiplies and adds.
    always_comb begin
        cls_cur   = class_of(state_reg);
        in_range  = (int'(pix_x) < SPR_W) && (int'(pix_y) < SPR_H);
        col_val   = state_reg[0] ? ADDR_W'(pix_x)
                                 : ADDR_W'(SPR_W - 1) - ADDR_W'(pix_x);
        addr_calc = bank_base[cls_cur]
                  + ADDR_W'(frame_reg) * ADDR_W'(FRAME_SZ)
                  + ADDR_W'(pix_y) * ADDR_W'(SPR_W)
                  + col_val;
    end

    // Stage 1: register the ROM address and out-of-range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            oob1_reg <= 1'b0;
            vld1_reg <= 1'b0;
        end else begin
            vld1_reg <= in_valid;
            if (in_valid) begin
                rom_addr <= in_range ? addr_calc : '0;
                oob1_reg <= !in_range;
            end
        end
    end

    // Stage 2: wait out the ROM read latency alongside the sidebands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld2_reg <= 1'b0;
            oob2_reg <= 1'b0;
        end else begin
            vld2_reg <= vld1_reg;
            oob2_reg <= oob1_reg;
        end
    end

    // Stage 3: capture the pixel and decide whether the mixer draws it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out    <= '0;
            pix_valid  <= 1'b0;
            pix_opaque <= 1'b0;
        end else begin
            pix_valid  <= vld2_reg;
            pix_opaque <= vld2_reg && (rom_data != KEY_COL) && !oob2_reg;
            if (vld2_reg)
                pix_out <= rom_data;
        end
    end

endmodule
